// File: rtl/fp_div_seq_if.sv
// Request/response bundle for fp_div_seq: start/operands in, busy/done/quotient/flags out.
// Requester drives the master side; start is only sampled while busy is low.
interface fp_div_seq_if #(
  parameter int W = 32
);
  logic         start;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic [3:0]   flags;

  modport master (output start, in_a, in_b, input busy, done, out, flags);
  modport slave  (input start, in_a, in_b, output busy, done, out, flags);
endinterface

// File: rtl/fp_div_seq.sv
// Sequential IEEE-style divider (denormals flushed); FP_DIV_RNE_EN selects round-to-nearest-even, else truncate.
// Latency 2 edges for special operands, MAN_W+5 otherwise; start ignored while busy, out/flags held until next done.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_div_seq_if.slave  bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int N  = MAN_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] ONES_S = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_S = EW'(0);

  typedef enum logic [2:0] {IDLE, CLASSIFY, DIVIDE, ROUND, DONE} state_t;

  state_t                 r_state, w_next;
  logic [W-1:0]           r_a, r_b, r_res, r_out;
  logic [3:0]             r_flg, r_flags;
  logic                   r_done, r_sign;
  logic [MAN_W+1:0]       r_rem;
  logic [N-1:0]           r_quo;
  logic signed [EW-1:0]   r_exp;
  logic [CW-1:0]          r_cnt;

  logic                   w_sa, w_sb;
  logic [EXP_W-1:0]       w_ea, w_eb;
  logic [MAN_W-1:0]       w_ma, w_mb;
  logic                   w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic                   w_nan, w_special;
  logic [W-1:0]           w_spec_res;
  logic [3:0]             w_spec_flg;

  assign w_sa = r_a[W-1];
  assign w_sb = r_b[W-1];
  assign w_ea = r_a[W-2 -: EXP_W];
  assign w_eb = r_b[W-2 -: EXP_W];
  assign w_ma = r_a[MAN_W-1:0];
  assign w_mb = r_b[MAN_W-1:0];

  assign w_a_zero  = (w_ea == '0);
  assign w_b_zero  = (w_eb == '0);
  assign w_a_inf   = (w_ea == '1) && (w_ma == '0);
  assign w_b_inf   = (w_eb == '1) && (w_mb == '0);
  assign w_a_nan   = (w_ea == '1) && (w_ma != '0);
  assign w_b_nan   = (w_eb == '1) && (w_mb != '0);
  assign w_nan     = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
  assign w_special = w_nan | w_a_zero | w_b_zero | w_a_inf | w_b_inf;

  always_comb begin
    w_spec_res = {w_sa ^ w_sb, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    w_spec_flg = 4'b0000;
    if (w_nan) begin
      w_spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_spec_flg = 4'b1000;
    end else if (w_b_zero) begin
      w_spec_res = {w_sa ^ w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_spec_flg = 4'b0100;
    end else if (w_a_inf) begin
      w_spec_res = {w_sa ^ w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // Restoring step; CLASSIFY seeds the remainder with the dividend and retires the first quotient bit.
  logic [MAN_W+1:0]     w_rem_in, w_dvs, w_diff, w_rem_nx;
  logic                 w_ge;
  logic signed [EW-1:0] w_exp_cls;

  assign w_rem_in  = (r_state == CLASSIFY) ? {2'b01, w_ma} : r_rem;
  assign w_dvs     = {2'b01, w_mb};
  assign w_ge      = (w_rem_in >= w_dvs);
  assign w_diff    = w_ge ? (w_rem_in - w_dvs) : w_rem_in;
  assign w_rem_nx  = w_diff << 1;
  assign w_exp_cls = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + BIAS_S;

  logic                 w_lz, w_grd, w_stk;
  logic [MAN_W-1:0]     w_man, w_man_r;
  logic signed [EW-1:0] w_exp_n, w_exp_r;
  logic [W-1:0]         w_rnd_res;
  logic [3:0]           w_rnd_flg;

  assign w_lz    = ~r_quo[N-1];
  assign w_man   = w_lz ? r_quo[N-3:1] : r_quo[N-2:2];
  assign w_grd   = w_lz ? r_quo[0] : r_quo[1];
  assign w_stk   = (~w_lz & r_quo[0]) | (|r_rem);
  assign w_exp_n = r_exp - (w_lz ? ONE_S : ZERO_S);

`ifdef FP_DIV_RNE_EN
  logic             w_inc, w_cy;
  assign w_inc            = w_grd & (w_stk | w_man[0]);
  assign {w_cy, w_man_r}  = {1'b0, w_man} + (MAN_W+1)'(w_inc);
  assign w_exp_r          = w_exp_n + (w_cy ? ONE_S : ZERO_S);
`else
  logic             w_unused_rnd;
  assign w_unused_rnd = &{1'b0, w_grd, w_stk};
  assign w_man_r      = w_man;
  assign w_exp_r      = w_exp_n;
`endif

  always_comb begin
    w_rnd_res = {r_sign, w_exp_r[EXP_W-1:0], w_man_r};
    w_rnd_flg = 4'b0000;
    if (w_exp_r >= ONES_S) begin
      w_rnd_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_rnd_flg = 4'b0010;
    end else if (w_exp_r <= ZERO_S) begin
      w_rnd_res = {r_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      w_rnd_flg = 4'b0001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (bus.start) w_next = CLASSIFY;
      CLASSIFY: w_next = w_special ? DONE : DIVIDE;
      DIVIDE:   if (r_cnt == CW'(N - 1)) w_next = ROUND;
      ROUND:    w_next = DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_flg   <= '0;
      r_out   <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
      r_sign  <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_exp   <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a <= bus.in_a;
            r_b <= bus.in_b;
          end
        end
        CLASSIFY: begin
          r_sign <= w_sa ^ w_sb;
          r_res  <= w_spec_res;
          r_flg  <= w_spec_flg;
          r_exp  <= w_exp_cls;
          r_rem  <= w_rem_nx;
          r_quo  <= {{(N-1){1'b0}}, w_ge};
          r_cnt  <= CW'(1);
        end
        DIVIDE: begin
          r_rem <= w_rem_nx;
          r_quo <= {r_quo[N-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        ROUND: begin
          r_res <= w_rnd_res;
          r_flg <= w_rnd_flg;
        end
        DONE: begin
          r_out   <= r_res;
          r_flags <= r_flg;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (r_state != IDLE);
  assign bus.done  = r_done;
  assign bus.out   = r_out;
  assign bus.flags = r_flags;
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: expected results queued at issue, popped and compared at done.
module tb_fp_div_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_div_seq_if #(.W(32)) bus ();

  fp_div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] o;
    logic [3:0]  f;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   acc_cyc = 0;

`ifdef FP_DIV_RNE_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in_a  = a;
    bus.in_b  = b;
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n    = 0;
    bit   seen = 1'b0;
    while (n < 200 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) seen = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
    end
    if (seen) begin
      chk({tag, "_out"},   bus.out, e.o);
      chk({tag, "_flags"}, 32'(bus.flags), 32'(e.f));
      chk({tag, "_lat"},   32'(cyc - acc_cyc), 32'(e.lat));
      chk({tag, "_busy_with_done"}, 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eo,
                    input logic [3:0] ef, input int lat, input string tag);
    exp_t e;
    e.o = eo;
    e.f = ef;
    e.lat = lat;
    sb.push_back(e);
    start_op(a, b);
    wait_done(tag);
  endtask

  task automatic count_dones(input int ncyc, output int nd);
    nd = 0;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      if (bus.done) nd++;
    end
  endtask

  initial begin
    int   nd;
    exp_t e;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_out",   bus.out, 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    rst_n = 1'b1;

    op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, "six_div_two");
    op(32'h3F800000, 32'h40400000, THIRD,        4'b0000, 28, "one_third");
    op(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 2,  "neg_div_zero");
    op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2,  "zero_div_zero");
    op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 28, "overflow");
    op(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28, "underflow");
    op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2,  "nan_operand");
    op(32'hFF800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2,  "inf_div_inf");
    op(32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 2,  "inf_div_fin");
    op(32'h40400000, 32'h7F800000, 32'h00000000, 4'b0000, 2,  "fin_div_inf");
    op(32'h00000000, 32'hC0A00000, 32'h80000000, 4'b0000, 2,  "zero_div_neg");
    op(32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 2,  "denorm_flush");
    op(32'hC0F00000, 32'h40200000, 32'hC0400000, 4'b0000, 28, "neg_exact");

    // Abort a division with reset; outputs must clear and no done may follow.
    start_op(32'h40C00000, 32'h40000000);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  32'(bus.busy), 32'd0);
    chk("abort_done",  32'(bus.done), 32'd0);
    chk("abort_out",   bus.out, 32'd0);
    chk("abort_flags", 32'(bus.flags), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_dones(40, nd);
    chk("abort_no_done", 32'(nd), 32'd0);
    op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, "after_reset");

    // A second start while busy must be ignored, including the new operands.
    e.o = 32'h40400000;
    e.f = 4'b0000;
    e.lat = 28;
    sb.push_back(e);
    start_op(32'h40C00000, 32'h40000000);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.in_a  = 32'h3F800000;
    bus.in_b  = 32'h40400000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("start_while_busy");
    count_dones(40, nd);
    chk("single_done", 32'(nd), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
